// File: rtl/uart_mmio_host.sv
// -----------------------------------------------------------------------------
// uart_mmio_host
// Polling MMIO initiator for a UART register window. Converts a byte stream
// (valid/ready) into single-cycle MMIO reads/writes: it periodically reads
// STATUS, drains one received byte at a time into a one-entry RX buffer, and
// writes a pending TX byte only after a poll reports the transmitter idle.
//
// Register window (relative to BASE_ADDR):
//   +0 RX_DATA (read), +4 TX_DATA (write), +8 STATUS (bit0 rx_valid, bit1 tx_busy)
//
// Parameters:
//   BASE_ADDR   base of the UART register window
//   POLL_GAP    idle cycles between STATUS polls (0 behaves as 1)
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   o_mmio_addr         access address, 0 when no strobe
//   o_mmio_data_out     write data, 0 when o_mmio_we is low
//   i_mmio_data_in      read data, valid in the strobe cycle
//   o_mmio_we/o_mmio_re one-cycle write/read strobes, never both high
//   i_tx_data/i_tx_valid/o_tx_ready   transmit byte stream in
//   o_rx_data/o_rx_valid/i_rx_ready   received byte stream out
//
// Build option:
//   UART_MMIO_HOST_TX_FIFO_EN  defined   -> 4-entry TX FIFO
//                              undefined -> single TX holding register
// -----------------------------------------------------------------------------
module uart_mmio_host #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          POLL_GAP  = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_mmio_addr,
    output logic [7:0]  o_mmio_data_out,
    input  logic [7:0]  i_mmio_data_in,
    output logic        o_mmio_we,
    output logic        o_mmio_re,
    input  logic [7:0]  i_tx_data,
    input  logic        i_tx_valid,
    output logic        o_tx_ready,
    output logic [7:0]  o_rx_data,
    output logic        o_rx_valid,
    input  logic        i_rx_ready
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_POLL  = 3'd1;
    localparam logic [2:0] ST_RX_RD = 3'd2;
    localparam logic [2:0] ST_TX_WR = 3'd3;
    localparam logic [2:0] ST_GUARD = 3'd4;

    localparam int         GAP_EFF_I = (POLL_GAP < 1) ? 1 : POLL_GAP;
    localparam logic [7:0] GAP_EFF   = GAP_EFF_I[7:0];

    localparam logic [31:0] ADDR_RX     = BASE_ADDR;
    localparam logic [31:0] ADDR_TX     = BASE_ADDR + 32'd4;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'd8;

    logic [2:0]  state_r;
    logic [2:0]  state_next_s;
    logic [7:0]  gap_r;
    logic [7:0]  gap_next_s;

    logic [31:0] mmio_addr_r;
    logic [7:0]  mmio_data_r;
    logic        mmio_we_r;
    logic        mmio_re_r;

    logic [7:0]  rx_data_r;
    logic        rx_valid_r;
    logic        tx_ready_r;

    logic        tx_pending_s;
    logic [7:0]  tx_head_s;
    logic        tx_push_s;
    logic        tx_pop_s;
    logic        tx_full_next_s;

    assign tx_push_s = i_tx_valid && tx_ready_r;
    assign tx_pop_s  = (state_r == ST_TX_WR);

`ifdef UART_MMIO_HOST_TX_FIFO_EN
    logic [7:0] fifo_mem_r [0:3];
    logic [1:0] wr_ptr_r;
    logic [1:0] rd_ptr_r;
    logic [2:0] tx_count_r;
    logic [2:0] tx_count_next_s;

    assign tx_pending_s = (tx_count_r != 3'd0);
    assign tx_head_s    = fifo_mem_r[rd_ptr_r];

    // Occupancy after this edge; simultaneous push and pop leave it unchanged.
    always_comb begin
        tx_count_next_s = tx_count_r;
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_count_next_s = tx_count_r + 3'd1;
            2'b01:   tx_count_next_s = tx_count_r - 3'd1;
            default: tx_count_next_s = tx_count_r;
        endcase
    end

    assign tx_full_next_s = (tx_count_next_s == 3'd4);

    // TX FIFO storage, pointers and count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem_r[i] <= 8'h00;
            end
            wr_ptr_r   <= 2'd0;
            rd_ptr_r   <= 2'd0;
            tx_count_r <= 3'd0;
        end else begin
            if (tx_push_s) begin
                fifo_mem_r[wr_ptr_r] <= i_tx_data;
                wr_ptr_r             <= wr_ptr_r + 2'd1;
            end
            if (tx_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            tx_count_r <= tx_count_next_s;
        end
    end
`else
    logic [7:0] tx_hold_r;
    logic       tx_full_r;

    assign tx_pending_s = tx_full_r;
    assign tx_head_s    = tx_hold_r;

    // Push only happens while empty and pop only while full, so they never coincide.
    always_comb begin
        if (tx_push_s) begin
            tx_full_next_s = 1'b1;
        end else if (tx_pop_s) begin
            tx_full_next_s = 1'b0;
        end else begin
            tx_full_next_s = tx_full_r;
        end
    end

    // TX holding register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_hold_r <= 8'h00;
            tx_full_r <= 1'b0;
        end else begin
            if (tx_push_s) begin
                tx_hold_r <= i_tx_data;
            end
            tx_full_r <= tx_full_next_s;
        end
    end
`endif

    // Next-state and poll-gap counter; the counter is reloaded on every entry to IDLE.
    always_comb begin
        state_next_s = state_r;
        gap_next_s   = gap_r;
        case (state_r)
            ST_IDLE: begin
                if (gap_r <= 8'd1) begin
                    state_next_s = ST_POLL;
                end else begin
                    gap_next_s = gap_r - 8'd1;
                end
            end
            ST_POLL: begin
                // RX wins over TX; a full RX buffer masks the rx_valid bit.
                if (i_mmio_data_in[0] && !rx_valid_r) begin
                    state_next_s = ST_RX_RD;
                end else if (!i_mmio_data_in[1] && tx_pending_s) begin
                    state_next_s = ST_TX_WR;
                end else begin
                    state_next_s = ST_IDLE;
                    gap_next_s   = GAP_EFF;
                end
            end
            ST_RX_RD: begin
                state_next_s = ST_IDLE;
                gap_next_s   = GAP_EFF;
            end
            ST_TX_WR: begin
                state_next_s = ST_GUARD;
            end
            ST_GUARD: begin
                state_next_s = ST_IDLE;
                gap_next_s   = GAP_EFF;
            end
            default: begin
                state_next_s = ST_IDLE;
                gap_next_s   = GAP_EFF;
            end
        endcase
    end

    // State register plus MMIO outputs registered from the next state, so
    // outputs are a pure function of the state register contents.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            gap_r       <= GAP_EFF;
            mmio_addr_r <= 32'h0000_0000;
            mmio_data_r <= 8'h00;
            mmio_we_r   <= 1'b0;
            mmio_re_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            gap_r     <= gap_next_s;
            mmio_re_r <= (state_next_s == ST_POLL) || (state_next_s == ST_RX_RD);
            mmio_we_r <= (state_next_s == ST_TX_WR);
            // Head is stable while non-empty, so sampling it here matches the TX_WR pop.
            mmio_data_r <= (state_next_s == ST_TX_WR) ? tx_head_s : 8'h00;
            case (state_next_s)
                ST_POLL:  mmio_addr_r <= ADDR_STATUS;
                ST_RX_RD: mmio_addr_r <= ADDR_RX;
                ST_TX_WR: mmio_addr_r <= ADDR_TX;
                default:  mmio_addr_r <= 32'h0000_0000;
            endcase
        end
    end

    // One-entry RX buffer; RX_RD is only entered while it is empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_valid_r <= 1'b0;
            rx_data_r  <= 8'h00;
        end else if (state_r == ST_RX_RD) begin
            rx_valid_r <= 1'b1;
            rx_data_r  <= i_mmio_data_in;
        end else if (rx_valid_r && i_rx_ready) begin
            rx_valid_r <= 1'b0;
        end else begin
            rx_valid_r <= rx_valid_r;
        end
    end

    // Registered TX stream ready, tracking the storage occupancy after each edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_ready_r <= 1'b1;
        end else begin
            tx_ready_r <= !tx_full_next_s;
        end
    end

    assign o_mmio_addr     = mmio_addr_r;
    assign o_mmio_data_out = mmio_data_r;
    assign o_mmio_we       = mmio_we_r;
    assign o_mmio_re       = mmio_re_r;
    assign o_rx_data       = rx_data_r;
    assign o_rx_valid      = rx_valid_r;
    assign o_tx_ready      = tx_ready_r;

endmodule

// File: tb/tb_uart_mmio_host.sv
// -----------------------------------------------------------------------------
// tb_uart_mmio_host
// Self-checking bench for uart_mmio_host. A schedule-based reference model
// (absolute poll times, a byte queue for TX storage, a flag for the RX buffer)
// predicts every output each cycle; a few literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_uart_mmio_host;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          G    = 4;
`ifdef UART_MMIO_HOST_TX_FIFO_EN
    localparam int          CAP  = 4;
`else
    localparam int          CAP  = 1;
`endif

    localparam int K_NONE = 0;
    localparam int K_POLL = 1;
    localparam int K_RXRD = 2;
    localparam int K_TXWR = 3;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] o_mmio_addr;
    logic [7:0]  o_mmio_data_out;
    logic [7:0]  i_mmio_data_in;
    logic        o_mmio_we;
    logic        o_mmio_re;
    logic [7:0]  i_tx_data;
    logic        i_tx_valid;
    logic        o_tx_ready;
    logic [7:0]  o_rx_data;
    logic        o_rx_valid;
    logic        i_rx_ready;

    always #5 i_clk = ~i_clk;

    uart_mmio_host #(.BASE_ADDR(BASE), .POLL_GAP(G)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .o_mmio_addr    (o_mmio_addr),
        .o_mmio_data_out(o_mmio_data_out),
        .i_mmio_data_in (i_mmio_data_in),
        .o_mmio_we      (o_mmio_we),
        .o_mmio_re      (o_mmio_re),
        .i_tx_data      (i_tx_data),
        .i_tx_valid     (i_tx_valid),
        .o_tx_ready     (o_tx_ready),
        .o_rx_data      (o_rx_data),
        .o_rx_valid     (o_rx_valid),
        .i_rx_ready     (i_rx_ready)
    );

    int n_pass  = 0;
    int n_total = 0;

    // UART side stimulus: what STATUS and RX_DATA return when read.
    logic [7:0] uart_status = 8'h00;
    logic [7:0] uart_rxbyte = 8'h00;

    // Reference model state.
    logic [7:0] txq[$];
    bit         m_rx_full   = 1'b0;
    logic [7:0] m_rx_byte   = 8'h00;
    int         m_kind      = K_NONE;
    int         m_next_poll = 0;
    int         m_cyc       = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got %h, required %h", name, m_cyc, act, exp);
        end
    endtask

    // Advance the model over the current cycle using the inputs the DUT sees.
    task automatic model_step();
        int sz;
        bit pushed;
        int kn;
        if (i_rst) begin
            txq.delete();
            m_rx_full   = 1'b0;
            m_rx_byte   = 8'h00;
            m_cyc       = 0;
            m_next_poll = G;
            m_kind      = K_NONE;
            return;
        end
        sz     = txq.size();
        pushed = i_tx_valid && (sz < CAP);
        kn     = K_NONE;
        if (m_kind == K_POLL) begin
            if (i_mmio_data_in[0] && !m_rx_full) begin
                kn = K_RXRD;
                m_next_poll = m_cyc + 2 + G;
            end else if (!i_mmio_data_in[1] && sz > 0) begin
                kn = K_TXWR;
                m_next_poll = m_cyc + 3 + G;
            end else begin
                m_next_poll = m_cyc + 1 + G;
            end
        end
        if (m_kind == K_RXRD) begin
            m_rx_full = 1'b1;
            m_rx_byte = i_mmio_data_in;
        end else if (m_rx_full && i_rx_ready) begin
            m_rx_full = 1'b0;
        end
        if (m_kind == K_TXWR) begin
            void'(txq.pop_front());
        end
        if (pushed) begin
            txq.push_back(i_tx_data);
        end
        m_cyc++;
        if (m_kind != K_POLL) begin
            kn = (m_cyc == m_next_poll) ? K_POLL : K_NONE;
        end
        m_kind = kn;
    endtask

    task automatic compare();
        logic [31:0] e_addr;
        logic [7:0]  e_data;
        case (m_kind)
            K_POLL:  e_addr = BASE + 32'd8;
            K_RXRD:  e_addr = BASE;
            K_TXWR:  e_addr = BASE + 32'd4;
            default: e_addr = 32'h0;
        endcase
        e_data = (m_kind == K_TXWR) ? txq[0] : 8'h00;
        chk("re",       {31'd0, o_mmio_re}, {31'd0, (m_kind == K_POLL) || (m_kind == K_RXRD)});
        chk("we",       {31'd0, o_mmio_we}, {31'd0, (m_kind == K_TXWR)});
        chk("addr",     o_mmio_addr, e_addr);
        chk("wdata",    {24'd0, o_mmio_data_out}, {24'd0, e_data});
        chk("we_re_ex", {31'd0, o_mmio_we && o_mmio_re}, 32'd0);
        chk("tx_ready", {31'd0, o_tx_ready}, {31'd0, txq.size() < CAP});
        chk("rx_valid", {31'd0, o_rx_valid}, {31'd0, m_rx_full});
        chk("rx_data",  {24'd0, o_rx_data}, {24'd0, m_rx_byte});
    endtask

    // One clock: present the UART read response, step the model, then check.
    task automatic cycle();
        if (o_mmio_re === 1'b1 && o_mmio_addr == BASE + 32'd8) begin
            i_mmio_data_in = uart_status;
        end else if (o_mmio_re === 1'b1 && o_mmio_addr == BASE) begin
            i_mmio_data_in = uart_rxbyte;
        end else begin
            i_mmio_data_in = 8'($urandom);
        end
        model_step();
        @(posedge i_clk);
        #1;
        compare();
    endtask

    initial begin
        int seen;
        int rd_cnt;

        i_rst       = 1'b1;
        i_tx_valid  = 1'b0;
        i_tx_data   = 8'h00;
        i_rx_ready  = 1'b0;
        i_mmio_data_in = 8'h00;
        cycle();
        cycle();
        chk("rst_tx_ready", {31'd0, o_tx_ready}, 32'd1);
        chk("rst_re",       {31'd0, o_mmio_re},  32'd0);
        chk("rst_addr",     o_mmio_addr,         32'd0);
        i_rst = 1'b0;

        // Idle polling: read strobes at cycles 4, 9, 14.
        uart_status = 8'h00;
        seen = 0;
        while (m_cyc < 15) begin
            cycle();
            if (m_cyc == 4 || m_cyc == 9 || m_cyc == 14) begin
                chk("poll_re",   {31'd0, o_mmio_re}, 32'd1);
                chk("poll_addr", o_mmio_addr, 32'h1000_0008);
                seen++;
            end
        end
        chk("poll_count", seen, 3);

        // Single TX byte with idle transmitter.
        i_tx_valid = 1'b1;
        i_tx_data  = 8'h55;
        cycle();
        i_tx_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            cycle();
            if (o_mmio_we) begin
                seen = 1;
                chk("tx_addr", o_mmio_addr, 32'h1000_0004);
                chk("tx_data", {24'd0, o_mmio_data_out}, 32'h55);
                cycle();
                chk("guard_strobes", {30'd0, o_mmio_we, o_mmio_re}, 32'd0);
                chk("tx_ready_after", {31'd0, o_tx_ready}, 32'd1);
            end
        end
        chk("tx_write_seen", seen, 1);

        // RX byte held while the consumer stalls.
        uart_status = 8'h01;
        uart_rxbyte = 8'hA5;
        rd_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (o_mmio_re && o_mmio_addr == 32'h1000_0000) begin
                rd_cnt++;
            end
        end
        chk("rx_rd_count",  rd_cnt, 1);
        chk("rx_hold_valid", {31'd0, o_rx_valid}, 32'd1);
        chk("rx_hold_data",  {24'd0, o_rx_data}, 32'hA5);
        i_rx_ready = 1'b1;
        cycle();
        i_rx_ready = 1'b0;
        chk("rx_released", {31'd0, o_rx_valid}, 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            uart_status = 8'($urandom);
            uart_rxbyte = 8'($urandom);
            i_tx_valid  = ($urandom_range(0, 1) == 1);
            i_tx_data   = 8'($urandom);
            i_rx_ready  = ($urandom_range(0, 3) == 0);
            i_rst       = ($urandom_range(0, 299) == 0);
            cycle();
        end

        // Final reset discards pending bytes.
        i_tx_valid = 1'b1;
        i_rst      = 1'b1;
        cycle();
        chk("final_rst_ready",   {31'd0, o_tx_ready}, 32'd1);
        chk("final_rst_strobes", {30'd0, o_mmio_we, o_mmio_re}, 32'd0);
        chk("final_rst_rxv",     {31'd0, o_rx_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
